// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, one operation in flight, WIDTH+2 edge latency.
// Optional macro DIV_UNIT_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_C  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    state_t           state_r, state_nxt_s;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] q_r, rem_r, div_r, a_raw_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_q_r, neg_r_r, div_zero_r, ovf_r;
    logic             busy_r, valid_r;
    logic [WIDTH-1:0] result_r;

    logic             signed_op_s, a_neg_s, b_neg_s, div_zero_s, ovf_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, rem_shift_s, q_fix_s, r_fix_s, res_s;
    logic [WIDTH:0]   diff_s;

    // Request decode: sign handling and special-case detection on the raw operands
    always_comb begin
        signed_op_s = ~op_i[0];
        a_neg_s     = signed_op_s & a_i[WIDTH-1];
        b_neg_s     = signed_op_s & b_i[WIDTH-1];
        a_mag_s     = a_neg_s ? neg_f(a_i) : a_i;
        b_mag_s     = b_neg_s ? neg_f(b_i) : b_i;
        div_zero_s  = (b_i == ZERO_C);
        ovf_s       = signed_op_s & (a_i == MIN_C) & (b_i == ONES_C);
    end

    // One restoring step: the borrow of the WIDTH+1 bit subtraction is the compare
    always_comb begin
        rem_shift_s = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
        diff_s      = {1'b0, rem_shift_s} - {1'b0, div_r};
    end

    // Sign correction and special-case override of the final result
    always_comb begin
        q_fix_s = neg_q_r ? neg_f(q_r) : q_r;
        r_fix_s = neg_r_r ? neg_f(rem_r) : rem_r;
        res_s   = ZERO_C;
        if (div_zero_r) begin
            res_s = op_r[1] ? a_raw_r : ONES_C;
        end else if (ovf_r) begin
            res_s = op_r[1] ? ZERO_C : a_raw_r;
        end else begin
            res_s = op_r[1] ? r_fix_s : q_fix_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
`ifdef DIV_UNIT_EARLY_OUT_EN
                    if (div_zero_s || ovf_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
`else
                    state_nxt_s = ST_CALC;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_r       <= 2'b00;
            q_r        <= ZERO_C;
            rem_r      <= ZERO_C;
            div_r      <= ZERO_C;
            a_raw_r    <= ZERO_C;
            cnt_r      <= {CW{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            result_r   <= ZERO_C;
        end else begin
            busy_r  <= (state_nxt_s != ST_IDLE);
            valid_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        op_r       <= op_i;
                        q_r        <= a_mag_s;
                        rem_r      <= ZERO_C;
                        div_r      <= b_mag_s;
                        a_raw_r    <= a_i;
                        cnt_r      <= CW'(WIDTH - 1);
                        neg_q_r    <= a_neg_s ^ b_neg_s;
                        neg_r_r    <= a_neg_s;
                        div_zero_r <= div_zero_s;
                        ovf_r      <= ovf_s;
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (!diff_s[WIDTH]) begin
                        rem_r <= diff_s[WIDTH-1:0];
                        q_r   <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= rem_shift_s;
                        q_r   <= {q_r[WIDTH-2:0], 1'b0};
                    end
                end
                ST_DONE: result_r <= res_s;
                default: result_r <= result_r;
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign valid_o  = valid_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32): results, latency, busy length, hazards, reset abort.
module tb_div_unit;
    localparam int W = 32;
`ifdef DIV_UNIT_EARLY_OUT_EN
    localparam int SP_LAT = 2;
`else
    localparam int SP_LAT = 34;
`endif
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] a_i = 32'd0;
    logic [W-1:0] b_i = 32'd0;
    logic         busy_o, valid_o;
    logic [W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a request at the next edge and waits (bounded) for valid_o.
    // lat counts edges from T0 inclusive; hold keeps start_i high during busy with dummy operands.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk_i); #1;
        if (hold) begin
            op_i = OP_DIVU; a_i = 32'd1; b_i = 32'd1;
        end else begin
            start_i = 1'b0;
        end
        lat = 1; bcnt = 0;
        while (!valid_o && lat < 100) begin
            if (busy_o) bcnt++;
            @(posedge clk_i); #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat, bcnt;
        run_op(op, a, b, 1'b0, res, lat, bcnt);
        check_eq({tag, "_res"}, res, exp);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy"}, 32'(bcnt), 32'(exp_lat - 1));
        @(posedge clk_i); #1;
        check_eq({tag, "_pulse"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int lat, bcnt, pulses;

        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        @(negedge clk_i); rst_i = 1'b0;

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        do_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        do_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34);
        do_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 34);
        do_op("divu_z", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SP_LAT);
        do_op("div_z", OP_DIV, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, SP_LAT);
        do_op("rem_z", OP_REM, 32'h1234_5678, 32'd0, 32'h1234_5678, SP_LAT);
        do_op("remu_z", OP_REMU, 32'hF000_0001, 32'd0, 32'hF000_0001, SP_LAT);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SP_LAT);
        do_op("divu_noovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        // start_i held during busy is ignored; a start in the valid cycle is accepted
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, res, lat, bcnt);
        check_eq("hold_res", res, 32'd14);
        check_eq("hold_lat", 32'(lat), 32'd34);
        op_i = OP_DIVU; a_i = 32'd45; b_i = 32'd5;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check_eq("b2b_pulse", {31'd0, valid_o}, 32'd0);
        check_eq("b2b_busy", {31'd0, busy_o}, 32'd1);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check_eq("b2b_res", result_o, 32'd9);
        check_eq("b2b_lat", 32'(lat), 32'd34);

        // reset during iteration 10 aborts without a valid pulse
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        check_eq("abort_valid", {31'd0, valid_o}, 32'd0);
        check_eq("abort_result", result_o, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) pulses++;
        end
        check_eq("abort_nopulse", 32'(pulses), 32'd0);
        do_op("after_abort", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative restoring divider for the RISC-V M-extension ops DIV, DIVU, REM and REMU.
- Each iteration performs one trial subtraction, the inverse of the ripple-carry adder path.
- Sits beside the ALU. The core stalls on busy_o and captures result_o on valid_o.
- Fixed latency, one operation in flight.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  request; sampled only when busy_o=0
- op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; sampled with start_i
- a_i  input  WIDTH  dividend; sampled with start_i
- b_i  input  WIDTH  divisor; sampled with start_i
- busy_o  output  1  high while an operation is in progress
- valid_o  output  1  one-cycle pulse, result_o valid
- result_o  output  WIDTH  quotient or remainder per op

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE, busy_o=0, valid_o=0, result_o=0, internal registers cleared.
  - Reset overrides start_i and aborts any operation in flight with no valid_o pulse.
- States:
  - IDLE: busy_o=0. start_i=1 at edge T0 latches op, operand magnitudes, sign flags and divZero/overflow flags; clears remainder reg; loads iteration counter with WIDTH-1; goes to CALC.
  - CALC: busy_o=1. Each edge:
    - rem = {rem[WIDTH-2:0], q[WIDTH-1]}
    - q shifts left
    - if rem >= divisor then rem -= divisor and q[0]=1, else q[0]=0
    - The subtraction is WIDTH+1 bits wide and its borrow decides the compare.
    - After the WIDTH-th iteration (edge TWIDTH), go to DONE.
  - DONE: busy_o=1. Next edge T(WIDTH+1) registers the sign-corrected result into result_o, pulses valid_o=1 for one cycle, returns to IDLE.
- Latency: valid_o is high in the cycle after edge T(WIDTH+1), i.e. WIDTH+2 edges counting T0. For WIDTH=32, valid follows the 34th edge.
- Back-to-back: start_i is accepted in the same cycle valid_o is high (state is already IDLE).
- start_i while busy_o=1: ignored. Operands and op are not re-sampled.
- Signed ops (DIV, REM):
  - Magnitudes are used internally.
  - The quotient is negated when the dividend and divisor signs differ.
  - The remainder takes the sign of the dividend.
- Unsigned ops use raw operands.
- Divide by zero (b=0):
  - Quotient is all ones for both DIV and DIVU.
  - Remainder equals a_i unmodified.
  - No exception is raised.
- Signed overflow (DIV/REM with a=-2^(WIDTH-1), b=-1):
  - Quotient = a_i.
  - Remainder = 0.
- Special-case results take the full WIDTH+2 latency unless the optional feature is enabled.
- result_o holds its value until the next completion or reset; valid_o=0 otherwise.

Optional Feature:
- Macro DIV_UNIT_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow requests skip CALC (IDLE to DONE at T0). result_o and valid_o then appear after edge T1, i.e. 2-cycle latency; busy_o=1 for one cycle only. Normal divisions are unchanged.
- Undefined: all requests take fixed WIDTH+2 latency. No early-out logic is synthesized.

Test Plan:
- DIVU, a=100, b=7, WIDTH=32 -> busy_o high for 33 cycles; valid_o pulses once after the 34th edge with result_o=14. REMU on the same operands -> 2.
- DIV, a=-7 (0xFFFFFFF9), b=2 -> result_o=0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1). DIV, a=7, b=-2 -> 0xFFFFFFFD.
- DIVU, a=0x12345678, b=0 -> 0xFFFFFFFF. REM, a=0x12345678, b=0 -> 0x12345678. Latency is 34 edges without the macro and 2 edges with DIV_UNIT_EARLY_OUT_EN.
- DIV, a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- DIVU 100/7 started, then start_i held high with a=1, b=1 during busy -> only one valid_o pulse, result_o=14. A second start issued in the valid_o cycle completes 34 edges later.
- Start DIVU, assert rst_i at iteration 10 -> next cycle busy_o=0, valid_o=0, result_o=0, and no later valid_o pulse. A fresh request afterwards completes correctly.
